// File: rtl/bus_deskew_align.sv
// Two-lane deskew aligner: measures marker skew between lanes during calibration,
// then delays the earlier lane so both buses and markers leave on the same cycle.
module bus_deskew_align #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned MAX_SKEW  = 7,
  parameter int unsigned SKEW_W    = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cal_start,
  input  logic [BUS_WIDTH-1:0] a_bus,
  input  logic                 a_mark,
  input  logic [BUS_WIDTH-1:0] b_bus,
  input  logic                 b_mark,
  output logic [BUS_WIDTH-1:0] a_out,
  output logic [BUS_WIDTH-1:0] b_out,
  output logic                 out_mark,
  output logic                 locked,
  output logic                 cal_err,
  output logic [SKEW_W-1:0]    skew,
  output logic                 b_late
);

  localparam int unsigned LW = BUS_WIDTH + 1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_MEASURE, S_LOCKED, S_ERR} state_t;

  state_t            state_q, state_d;
  logic [SKEW_W-1:0] cnt_q, cnt_d;
  logic [SKEW_W-1:0] skew_q, skew_d;
  logic              first_a_q, first_a_d;
  logic              b_late_q, b_late_d;
  logic              locked_q, locked_d;
  logic              cal_err_q, cal_err_d;
  logic              first_mark, other_mark;

  logic [LW-1:0]        a_chain_q [1:MAX_SKEW];
  logic [LW-1:0]        b_chain_q [1:MAX_SKEW];
  logic [LW-1:0]        a_tap [0:MAX_SKEW];
  logic [LW-1:0]        b_tap [0:MAX_SKEW];
  logic [LW-1:0]        a_sel, b_sel;
  logic [SKEW_W-1:0]    a_idx, b_idx;
  logic [BUS_WIDTH-1:0] a_out_q, b_out_q;
  logic                 out_mark_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    skew_d     = skew_q;
    first_a_d  = first_a_q;
    b_late_d   = b_late_q;
    locked_d   = locked_q;
    cal_err_d  = cal_err_q;
    first_mark = first_a_q ? a_mark : b_mark;
    other_mark = first_a_q ? b_mark : a_mark;
    if (cal_start) begin
      state_d   = S_WAIT;
      cnt_d     = '0;
      locked_d  = 1'b0;
      cal_err_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (a_mark && b_mark) begin
            state_d  = S_LOCKED;
            skew_d   = '0;
            b_late_d = 1'b0;
            locked_d = 1'b1;
          end else if (a_mark || b_mark) begin
            state_d   = S_MEASURE;
            first_a_d = a_mark;
            cnt_d     = SKEW_W'(1);
          end
        end
        S_MEASURE: begin
          // A repeat of the first lane (even alongside the other lane) is a failure.
          if (first_mark) begin
            state_d   = S_ERR;
            cal_err_d = 1'b1;
          end else if (other_mark) begin
            state_d  = S_LOCKED;
            skew_d   = cnt_q;
            b_late_d = first_a_q;
            locked_d = 1'b1;
          end else if (cnt_q == SKEW_W'(MAX_SKEW)) begin
            state_d   = S_ERR;
            cal_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + SKEW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Taps are selected from the next-state skew so a fresh lock aligns on its first cycle.
  always_comb begin
    a_tap[0] = {a_mark, a_bus};
    b_tap[0] = {b_mark, b_bus};
    for (int unsigned k = 1; k <= MAX_SKEW; k++) begin
      a_tap[k] = a_chain_q[k];
      b_tap[k] = b_chain_q[k];
    end
    a_idx = b_late_d ? skew_d : '0;
    b_idx = b_late_d ? '0 : skew_d;
    a_sel = '0;
    b_sel = '0;
    for (int unsigned k = 0; k <= MAX_SKEW; k++) begin
      if (a_idx == SKEW_W'(k)) a_sel = a_tap[k];
      if (b_idx == SKEW_W'(k)) b_sel = b_tap[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      skew_q     <= '0;
      first_a_q  <= 1'b0;
      b_late_q   <= 1'b0;
      locked_q   <= 1'b0;
      cal_err_q  <= 1'b0;
      a_out_q    <= '0;
      b_out_q    <= '0;
      out_mark_q <= 1'b0;
      for (int unsigned k = 1; k <= MAX_SKEW; k++) begin
        a_chain_q[k] <= '0;
        b_chain_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      skew_q     <= skew_d;
      first_a_q  <= first_a_d;
      b_late_q   <= b_late_d;
      locked_q   <= locked_d;
      cal_err_q  <= cal_err_d;
      a_out_q    <= a_sel[BUS_WIDTH-1:0];
      b_out_q    <= b_sel[BUS_WIDTH-1:0];
      out_mark_q <= a_sel[BUS_WIDTH] & b_sel[BUS_WIDTH] & locked_d;
      a_chain_q[1] <= {a_mark, a_bus};
      b_chain_q[1] <= {b_mark, b_bus};
      for (int unsigned k = 2; k <= MAX_SKEW; k++) begin
        a_chain_q[k] <= a_chain_q[k-1];
        b_chain_q[k] <= b_chain_q[k-1];
      end
    end
  end

  assign a_out    = a_out_q;
  assign b_out    = b_out_q;
  assign out_mark = out_mark_q;
  assign locked   = locked_q;
  assign cal_err  = cal_err_q;
  assign skew     = skew_q;
  assign b_late   = b_late_q;

endmodule

// File: tb/tb_bus_deskew_align.sv
// Bench for bus_deskew_align: directed calibration scenarios plus random traffic,
// checked every cycle against a timestamp-based reference model.
module tb_bus_deskew_align;

  localparam int BW   = 8;
  localparam int MS   = 7;
  localparam int SW   = 3;
  localparam int NCYC = 4096;

  logic          clk = 1'b0;
  logic          rst = 1'b0, cal_start = 1'b0, a_mark = 1'b0, b_mark = 1'b0;
  logic [BW-1:0] a_bus = '0, b_bus = '0;
  logic [BW-1:0] a_out, b_out;
  logic          out_mark, locked, cal_err, b_late;
  logic [SW-1:0] skew;

  always #5 clk = ~clk;

  bus_deskew_align #(.BUS_WIDTH(BW), .MAX_SKEW(MS), .SKEW_W(SW)) dut (
    .clk(clk), .rst(rst), .cal_start(cal_start),
    .a_bus(a_bus), .a_mark(a_mark), .b_bus(b_bus), .b_mark(b_mark),
    .a_out(a_out), .b_out(b_out), .out_mark(out_mark),
    .locked(locked), .cal_err(cal_err), .skew(skew), .b_late(b_late)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Input history, indexed by cycle number.
  logic [BW-1:0] ah [NCYC];
  logic [BW-1:0] bh [NCYC];
  bit            amh[NCYC], bmh[NCYC], rh[NCYC], ch[NCYC];

  int last_rst = -1;
  int cal_cyc  = -1;
  bit resolved = 1'b0;
  bit m_locked = 1'b0, m_err = 1'b0, m_blate = 1'b0;
  int m_skew   = 0;

  function automatic logic [BW:0] tap_a(input int j);
    return (j <= last_rst) ? '0 : {amh[j], ah[j]};
  endfunction

  function automatic logic [BW:0] tap_b(input int j);
    return (j <= last_rst) ? '0 : {bmh[j], bh[j]};
  endfunction

  // Outcome from marker timestamps since the last cal_start: te is the first mark;
  // within te+1..te+MS the first further mark decides (early lane again -> error,
  // late lane alone -> lock with skew = distance); none by te+MS -> error.
  task automatic model_update(input int c);
    int te;
    bit e_is_a, e_mark, l_mark;
    if (rh[c]) begin
      last_rst = c; cal_cyc = -1; resolved = 1'b0;
      m_locked = 1'b0; m_err = 1'b0; m_skew = 0; m_blate = 1'b0;
    end else if (ch[c]) begin
      cal_cyc = c; resolved = 1'b0; m_locked = 1'b0; m_err = 1'b0;
    end else if (cal_cyc >= 0 && !resolved) begin
      te = -1;
      for (int j = cal_cyc + 1; j <= c; j++) begin
        if (amh[j] || bmh[j]) begin te = j; break; end
      end
      if (te == c) begin
        if (amh[c] && bmh[c]) begin
          m_locked = 1'b1; m_skew = 0; m_blate = 1'b0; resolved = 1'b1;
        end
      end else if (te >= 0) begin
        e_is_a = amh[te];
        e_mark = e_is_a ? amh[c] : bmh[c];
        l_mark = e_is_a ? bmh[c] : amh[c];
        if (e_mark) begin
          m_err = 1'b1; resolved = 1'b1;
        end else if (l_mark) begin
          m_locked = 1'b1; m_skew = c - te; m_blate = e_is_a; resolved = 1'b1;
        end else if (c - te == MS) begin
          m_err = 1'b1; resolved = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_outputs(input int c);
    logic [BW:0] ta, tb;
    logic        om;
    if (rh[c]) begin
      ta = '0; tb = '0; om = 1'b0;
    end else begin
      ta = tap_a(c - (m_blate ? m_skew : 0));
      tb = tap_b(c - (m_blate ? 0 : m_skew));
      om = ta[BW] & tb[BW] & m_locked;
    end
    check("a_out",    32'(a_out),    32'(ta[BW-1:0]));
    check("b_out",    32'(b_out),    32'(tb[BW-1:0]));
    check("out_mark", 32'(out_mark), 32'(om));
    check("locked",   32'(locked),   32'(m_locked));
    check("cal_err",  32'(cal_err),  32'(m_err));
    check("skew",     32'(skew),     32'(m_skew));
    check("b_late",   32'(b_late),   32'(m_blate));
  endtask

  task automatic step(input bit r, input bit c, input bit am, input bit bm,
                      input logic [BW-1:0] ad, input logic [BW-1:0] bd);
    @(negedge clk);
    rst = r; cal_start = c; a_mark = am; b_mark = bm; a_bus = ad; b_bus = bd;
    rh[cyc] = r; ch[cyc] = c; amh[cyc] = am; bmh[cyc] = bm; ah[cyc] = ad; bh[cyc] = bd;
    @(posedge clk);
    #1;
    model_update(cyc);
    compare_outputs(cyc);
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0, BW'($urandom), BW'($urandom));
  endtask

  task automatic cal();
    step(1'b0, 1'b1, 1'($urandom), 1'($urandom), BW'($urandom), BW'($urandom));
  endtask

  task automatic pair(input bit a_first, input int gap);
    if (gap == 0) begin
      step(1'b0, 1'b0, 1'b1, 1'b1, BW'($urandom), BW'($urandom));
    end else begin
      step(1'b0, 1'b0, a_first, !a_first, BW'($urandom), BW'($urandom));
      idle(gap - 1);
      step(1'b0, 1'b0, !a_first, a_first, BW'($urandom), BW'($urandom));
    end
  endtask

  initial begin
    // Reset with toggling inputs, then marks without cal_start.
    repeat (2) step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), BW'($urandom), BW'($urandom));
    check("rst_locked", 32'(locked), 32'd0);
    repeat (6) step(1'b0, 1'b0, 1'($urandom), 1'($urandom), BW'($urandom), BW'($urandom));
    check("nocal_locked", 32'(locked), 32'd0);

    // Zero skew.
    cal(); idle(2);
    step(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22);
    check("zs_a_out", 32'(a_out), 32'h11);
    check("zs_b_out", 32'(b_out), 32'h22);
    check("zs_mark",  32'(out_mark), 32'd1);
    check("zs_lock",  32'(locked), 32'd1);
    idle(3);

    // B late by 3, then marked stream.
    cal(); idle(1); pair(1'b1, 3);
    check("b3_skew", 32'(skew), 32'd3);
    check("b3_late", 32'(b_late), 32'd1);
    check("b3_mark", 32'(out_mark), 32'd1);
    repeat (4) begin pair(1'b1, 3); idle(2); end

    // A late by MAX_SKEW.
    cal(); pair(1'b0, MS);
    check("a7_skew", 32'(skew), 32'(MS));
    check("a7_late", 32'(b_late), 32'd0);
    repeat (3) begin pair(1'b0, MS); idle(1); end

    // Timeout: no second lane within MAX_SKEW cycles.
    cal(); step(1'b0, 1'b0, 1'b1, 1'b0, BW'($urandom), BW'($urandom));
    idle(MS - 1);
    check("to_pre_err", 32'(cal_err), 32'd0);
    idle(1);
    check("to_err", 32'(cal_err), 32'd1);
    check("to_lock", 32'(locked), 32'd0);
    cal();
    check("to_clear", 32'(cal_err), 32'd0);

    // Repeated first-lane mark.
    step(1'b0, 1'b0, 1'b1, 1'b0, BW'($urandom), BW'($urandom));
    idle(1);
    step(1'b0, 1'b0, 1'b1, 1'b0, BW'($urandom), BW'($urandom));
    check("rep_err", 32'(cal_err), 32'd1);
    cal();
    check("rep_clear", 32'(cal_err), 32'd0);

    // Reset during measurement.
    step(1'b0, 1'b0, 1'b1, 1'b0, BW'($urandom), BW'($urandom));
    idle(1);
    step(1'b1, 1'b0, 1'b0, 1'b1, BW'($urandom), BW'($urandom));
    check("rm_skew", 32'(skew), 32'd0);
    check("rm_a_out", 32'(a_out), 32'd0);
    idle(4);
    check("rm_idle_lock", 32'(locked), 32'd0);

    // Recalibrate from a skew-3 lock to skew 1.
    cal(); pair(1'b1, 3); idle(2);
    check("rc_skew3", 32'(skew), 32'd3);
    cal();
    check("rc_drop", 32'(locked), 32'd0);
    pair(1'b1, 1);
    check("rc_skew1", 32'(skew), 32'd1);
    check("rc_lock", 32'(locked), 32'd1);
    idle(3);

    // Random traffic with occasional calibration and reset.
    repeat (1500) begin
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
           BW'($urandom), BW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bus_deskew_align.md
# bus_deskew_align

Two-lane bus aligner for paths with unequal, unknown fixed delays, for example lanes that went through delay lines of different depth. During a calibration window it measures the arrival skew between a marker pulse on lane A and lane B. It then delays the earlier lane by that skew so both buses and their markers leave on the same cycle. It sits at the receiving end of a delayed multi-lane path, just before logic that consumes both lanes as one word.

## Interface
- BUS_WIDTH, 8, data width per lane
- MAX_SKEW, 7, largest skew in cycles that can be measured and compensated; must be ≥1
- SKEW_W, 3, width of the skew counter and result; 2^SKEW_W must be > MAX_SKEW
- clk  input  1  single clock, all state on posedge
- rst  input  1  reset, synchronous, active-high
- cal_start  input  1  one-cycle pulse; starts or restarts calibration
- a_bus  input  BUS_WIDTH  lane A data
- a_mark  input  1  lane A marker pulse
- b_bus  input  BUS_WIDTH  lane B data
- b_mark  input  1  lane B marker pulse
- a_out  output  BUS_WIDTH  aligned lane A data
- b_out  output  BUS_WIDTH  aligned lane B data
- out_mark  output  1  aligned markers coincide; gated by locked
- locked  output  1  skew valid; alignment active
- cal_err  output  1  calibration failed
- skew  output  SKEW_W  measured skew in cycles
- b_late  output  1  1 means lane B arrived later, so lane A is delayed

## Operation
- Delay lines:
  - Each lane has a MAX_SKEW-deep register chain carrying {mark, data}.
  - The chains are cleared to 0 by rst.
  - Tap 0 is the undelayed input; tap k is the input delayed by k cycles.
- Output taps:
  - The early lane uses tap `skew`; the late lane uses tap 0.
  - a_out and b_out are registered from the selected taps.
  - Tap selection changes only on entry to LOCKED.
  - Outside LOCKED, the taps keep the last locked values (0 after reset).
- FSM states: IDLE, WAIT, MEASURE, LOCKED, ERR.
  - **IDLE** (reset state): cal_start → WAIT.
  - **WAIT:**
    - a_mark and b_mark in the same cycle → LOCKED with skew=0, b_late=0.
    - Only one mark → MEASURE. Record which lane marked first; cnt=1.
    - No timeout in WAIT.
  - **MEASURE:**
    - The other lane's mark arrives while cnt=n → LOCKED with skew=n. b_late=1 if A marked first.
    - The first lane marks again before the other lane, including both marking in the same cycle → ERR.
    - Otherwise cnt increments.
    - cnt==MAX_SKEW with no other mark that cycle → ERR.
  - **LOCKED:** locked=1; marks are ignored for state purposes.
  - **ERR:** cal_err=1; skew and b_late hold their prior values.
  - cal_start from any state except IDLE → WAIT on the next cycle. cal_err and locked clear at that point.
- out_mark = aligned A mark AND aligned B mark AND locked.

## Timing
- rst dominates cal_start. Reset values:
  - a_out, b_out, out_mark, locked, cal_err, skew, b_late: all 0
  - state: IDLE; cnt: 0
- Output latency:
  - Late lane: 1 cycle.
  - Early lane: 1+skew cycles.
  - Aligned outputs: a_out(t) = a_bus(t−1−(b_late?skew:0)), with the matching rule for b_out.
- locked, skew and b_late update in the cycle after the second mark is sampled.
- New tap selection takes effect on a_out/b_out in that same cycle, registered from the new taps.
- ERR is entered in the cycle after the failing condition; cal_err is registered.
- cal_start has priority over mark decoding in the same cycle:
  - The state becomes WAIT.
  - Marks sampled with cal_start are ignored.
- rst during MEASURE or LOCKED:
  - Returns the block to IDLE and clears the chains.
  - Any measured skew is lost.
- Maximum measurable skew is MAX_SKEW, reached with cnt==MAX_SKEW on the other lane's mark. Skew MAX_SKEW+1 → cal_err.

## Test plan
- **Reset:**
  - Stimulus: hold rst 2 cycles with toggling inputs.
  - Required: all outputs 0; state IDLE. Marks without cal_start leave locked=0.
- **Zero skew:**
  - Stimulus: cal_start; then a_mark and b_mark in the same cycle with a_bus=0x11, b_bus=0x22.
  - Required:
    - Next cycle locked=1, skew=0, b_late=0.
    - a_out=0x11, b_out=0x22, out_mark=1 in the same cycle, one cycle after input.
- **B late by 3:**
  - Stimulus: cal_start; a_mark at cycle t; b_mark at t+3; then a marked data stream with b_mark arriving 3 cycles after a_mark.
  - Required:
    - locked=1 at t+4, skew=3, b_late=1.
    - Afterwards a_out lags a_bus by 4 cycles, b_out lags b_bus by 1, and out_mark pulses once per marker pair.
- **A late by MAX_SKEW (7):**
  - Stimulus: b_mark at t; a_mark at t+7.
  - Required: skew=7, b_late=0, b_out delayed by 8 cycles.
- **Timeout and repeated mark:**
  - Stimulus 1: a_mark at t, no b_mark through t+7.
    - Required: cal_err=1 at t+8, locked=0.
  - Stimulus 2: a_mark at t and t+2.
    - Required: cal_err=1 at t+3.
  - Stimulus 3: cal_start after either case.
    - Required: cal_err clears next cycle.
- **Reset mid-MEASURE and recalibration:**
  - Stimulus 1: rst asserted at cnt=2.
    - Required: IDLE, skew=0, outputs 0.
  - Stimulus 2: from LOCKED with skew=3, cal_start then a skew-1 pair.
    - Required: locked drops the cycle after cal_start, then re-locks with skew=1.
